// File: rtl/ub_host_reader_pkg.sv
// Shared types and defaults for the UB host readback engine.
package ub_host_reader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int LEN_W_DEF  = 7;
  localparam int DEPTH_DEF  = 8;
  localparam int BURST_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  function automatic int unsigned chunk_len(input int unsigned remaining, input int unsigned burst);
    return (remaining > burst) ? burst : remaining;
  endfunction

endpackage

// File: rtl/ub_rd_fifo.sv
// Circular buffer with two write lanes (lane 1 stored first) and one read port; head word is a register.
// Push of 0..2 words and a pop may coincide; the caller guarantees no overflow/underflow.
module ub_rd_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr1_en,
  input  logic [DATA_W-1:0]        i_wr1_dat,
  input  logic                     i_wr2_en,
  input  logic [DATA_W-1:0]        i_wr2_dat,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  w_wp2;

  // Lane 2 lands behind lane 1 when both are valid in the same cycle.
  assign w_wp2 = i_wr1_en ? (r_wp + PTR_W'(1)) : r_wp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_wr1_en) r_mem[r_wp]  <= i_wr1_dat;
      if (i_wr2_en) r_mem[w_wp2] <= i_wr2_dat;
      r_wp  <= r_wp + PTR_W'(i_wr1_en) + PTR_W'(i_wr2_en);
      if (i_rd_en) r_rp <= r_rp + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(i_wr1_en) + CNT_W'(i_wr2_en) - CNT_W'(i_rd_en);
    end
  end

  assign o_rd_dat = r_mem[r_rp];
  assign o_count  = r_cnt;
  assign o_empty  = (r_cnt == '0);

endmodule

// File: rtl/ub_host_reader.sv
// Host readback engine: splits a command into UB read bursts and streams returned words to the host.
// First request one cycle after accept; a burst is only issued once the FIFO can hold all of it.
module ub_host_reader
  import ub_host_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BURST  = BURST_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [ADDR_W-1:0] cmd_addr_in,
  input  logic [LEN_W-1:0]  cmd_len_in,
  output logic              ub_rd_start_out,
  output logic [ADDR_W-1:0] ub_rd_addr_out,
  output logic [ADDR_W-1:0] ub_rd_loc_out,
  input  logic [DATA_W-1:0] ub_rd_data_1_in,
  input  logic              ub_rd_valid_1_in,
  input  logic [DATA_W-1:0] ub_rd_data_2_in,
  input  logic              ub_rd_valid_2_in,
  output logic [DATA_W-1:0] host_data_out,
  output logic              host_valid_out,
  input  logic              host_ready_in,
  output logic              host_last_out,
  output logic              done_out,
  output logic              err_overflow_out
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_rd_loc;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_chunk;
  logic [LEN_W-1:0]  r_rcvd;
  logic [LEN_W-1:0]  r_out_cnt;
  logic              r_start;
  logic              r_done;
  logic              r_err;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic              w_empty;
  logic              w_pop;
  logic              w_in_wait;
  logic              w_acc1;
  logic              w_acc2;
  logic              w_drop;
  logic              w_space_ok;
  logic [LEN_W-1:0]  w_chunk;
  logic [LEN_W-1:0]  w_cmd_chunk;
  logic [LEN_W-1:0]  w_rcvd1;
  logic [LEN_W-1:0]  w_rcvd_nxt;

  assign w_chunk     = LEN_W'(chunk_len(32'(r_remaining), BURST));
  assign w_cmd_chunk = LEN_W'(chunk_len(32'(cmd_len_in), BURST));
  assign w_free      = CNT_W'(DEPTH) - w_count;
  assign w_space_ok  = (32'(w_free) >= 32'(w_chunk));

  // Only words still owed to the current burst are kept; anything else is an overflow.
  assign w_in_wait  = (r_state == ST_WAIT);
  assign w_acc1     = ub_rd_valid_1_in && w_in_wait && (r_rcvd < r_chunk);
  assign w_rcvd1    = r_rcvd + LEN_W'(w_acc1);
  assign w_acc2     = ub_rd_valid_2_in && w_in_wait && (w_rcvd1 < r_chunk);
  assign w_rcvd_nxt = w_rcvd1 + LEN_W'(w_acc2);
  assign w_drop     = (ub_rd_valid_1_in && !w_acc1) || (ub_rd_valid_2_in && !w_acc2);

  assign w_pop = !w_empty && host_ready_in;

  ub_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr1_en  (w_acc1),
    .i_wr1_dat (ub_rd_data_1_in),
    .i_wr2_en  (w_acc2),
    .i_wr2_dat (ub_rd_data_2_in),
    .i_rd_en   (w_pop),
    .o_rd_dat  (host_data_out),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_rd_loc    <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_rcvd      <= '0;
      r_out_cnt   <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (w_drop) r_err <= 1'b1;
      if (w_pop) r_out_cnt <= r_out_cnt + LEN_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            r_addr      <= cmd_addr_in;
            r_len       <= cmd_len_in;
            r_remaining <= cmd_len_in;
            r_out_cnt   <= '0;
            r_rcvd      <= '0;
            if (cmd_len_in == '0) begin
              r_done <= 1'b1;
            end else begin
              // FIFO is always empty in IDLE, so the first burst needs no space check.
              r_start   <= 1'b1;
              r_rd_addr <= cmd_addr_in;
              r_rd_loc  <= ADDR_W'(w_cmd_chunk);
              r_chunk   <= w_cmd_chunk;
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_ISSUE: begin
          if (w_space_ok) begin
            r_start   <= 1'b1;
            r_rd_addr <= r_addr;
            r_rd_loc  <= ADDR_W'(w_chunk);
            r_chunk   <= w_chunk;
            r_rcvd    <= '0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_rcvd_nxt == r_chunk) begin
            r_addr      <= r_addr + ADDR_W'(r_chunk);
            r_remaining <= r_remaining - r_chunk;
            r_rcvd      <= '0;
            r_state     <= (r_remaining == r_chunk) ? ST_DRAIN : ST_ISSUE;
          end else begin
            r_rcvd <= w_rcvd_nxt;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_out    = (r_state == ST_IDLE);
  assign ub_rd_start_out  = r_start;
  assign ub_rd_addr_out   = r_rd_addr;
  assign ub_rd_loc_out    = r_rd_loc;
  assign host_valid_out   = !w_empty;
  assign host_last_out    = !w_empty && (r_out_cnt == r_len - LEN_W'(1));
  assign done_out         = r_done;
  assign err_overflow_out = r_err;

endmodule

// File: tb/tb_ub_host_reader.sv
// Scoreboard bench for ub_host_reader: directed commands, a UB responder model, and request/word/done monitors.
module tb_ub_host_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [5:0]  cmd_addr_in;
  logic [6:0]  cmd_len_in;
  logic        ub_rd_start_out;
  logic [5:0]  ub_rd_addr_out;
  logic [5:0]  ub_rd_loc_out;
  logic [15:0] ub_rd_data_1_in;
  logic        ub_rd_valid_1_in;
  logic [15:0] ub_rd_data_2_in;
  logic        ub_rd_valid_2_in;
  logic [15:0] host_data_out;
  logic        host_valid_out;
  logic        host_ready_in;
  logic        host_last_out;
  logic        done_out;
  logic        err_overflow_out;

  always #5 clk = ~clk;

  ub_host_reader dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .cmd_addr_in      (cmd_addr_in),
    .cmd_len_in       (cmd_len_in),
    .ub_rd_start_out  (ub_rd_start_out),
    .ub_rd_addr_out   (ub_rd_addr_out),
    .ub_rd_loc_out    (ub_rd_loc_out),
    .ub_rd_data_1_in  (ub_rd_data_1_in),
    .ub_rd_valid_1_in (ub_rd_valid_1_in),
    .ub_rd_data_2_in  (ub_rd_data_2_in),
    .ub_rd_valid_2_in (ub_rd_valid_2_in),
    .host_data_out    (host_data_out),
    .host_valid_out   (host_valid_out),
    .host_ready_in    (host_ready_in),
    .host_last_out    (host_last_out),
    .done_out         (done_out),
    .err_overflow_out (err_overflow_out)
  );

  logic [16:0] exp_host[$];   // {last, data}
  logic [11:0] exp_req[$];    // {addr, loc}
  logic [15:0] ub_words[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int ub_mode = 0;
  bit ub_pause = 1'b0;
  bit lane_sel = 1'b0;
  int spur_req_n = 0;
  int spur_seen  = 0;
  logic [16:0] mon_e;
  logic [11:0] req_e;

  function automatic logic [15:0] ub_word(input logic [5:0] a);
    return 16'hC000 + 16'(a) * 16'd37;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic plan_words(input logic [5:0] a, input int len);
    logic [5:0] wa;
    for (int i = 0; i < len; i++) begin
      wa = a + 6'(i);
      exp_host.push_back({(i == len - 1), ub_word(wa)});
    end
  endtask

  task automatic push_req(input logic [5:0] a, input logic [5:0] loc);
    exp_req.push_back({a, loc});
  endtask

  task automatic send_cmd(input logic [5:0] a, input logic [6:0] l);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready_out && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_send", cmd_ready_out, 1);
    cmd_addr_in  = a;
    cmd_len_in   = l;
    cmd_valid_in = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk(name, done_cnt, target);
  endtask

  // UB responder: returns the words of each observed request in order.
  always @(posedge clk) begin
    #1;
    ub_rd_valid_1_in = 1'b0;
    ub_rd_valid_2_in = 1'b0;
    ub_rd_data_1_in  = '0;
    ub_rd_data_2_in  = '0;
    if (spur_req_n != spur_seen) begin
      ub_rd_valid_2_in = 1'b1;
      ub_rd_data_2_in  = 16'hDEAD;
      spur_seen++;
    end else if (!ub_pause && ub_words.size() > 0) begin
      if (ub_mode == 0) begin
        ub_rd_valid_1_in = 1'b1;
        ub_rd_data_1_in  = ub_words.pop_front();
        if (ub_words.size() > 0) begin
          ub_rd_valid_2_in = 1'b1;
          ub_rd_data_2_in  = ub_words.pop_front();
        end
      end else begin
        if (lane_sel) begin
          ub_rd_valid_2_in = 1'b1;
          ub_rd_data_2_in  = ub_words.pop_front();
        end else begin
          ub_rd_valid_1_in = 1'b1;
          ub_rd_data_1_in  = ub_words.pop_front();
        end
        lane_sel = !lane_sel;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ub_rd_start_out) begin
      start_cnt++;
      if (exp_req.size() == 0) begin
        chk("unexpected_ub_request", 1, 0);
      end else begin
        req_e = exp_req.pop_front();
        chk("ub_req_addr", ub_rd_addr_out, req_e[11:6]);
        chk("ub_req_loc", ub_rd_loc_out, req_e[5:0]);
      end
      for (int i = 0; i < int'(ub_rd_loc_out); i++)
        ub_words.push_back(ub_word(ub_rd_addr_out + 6'(i)));
    end
  end

  always @(negedge clk) begin
    if (rst && host_valid_out && host_ready_in) begin
      if (exp_host.size() == 0) begin
        chk("unexpected_host_word", 1, 0);
      end else begin
        mon_e = exp_host.pop_front();
        chk("host_data", host_data_out, mon_e[15:0]);
        chk("host_last", host_last_out, mon_e[16]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done_out) begin
      done_cnt++;
      chk("done_after_all_words", exp_host.size(), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    rst = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_addr_in = '0;
    cmd_len_in = '0;
    host_ready_in = 1'b1;
    ub_rd_valid_1_in = 1'b0;
    ub_rd_valid_2_in = 1'b0;
    ub_rd_data_1_in = '0;
    ub_rd_data_2_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_out, 1);
    chk("rst_host_valid", host_valid_out, 0);
    chk("rst_start", ub_rd_start_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_overflow_out, 0);
    chk("rst_last", host_last_out, 0);
    chk("rst_host_data", host_data_out, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // addr 0x10, len 4, two words per cycle, with latency checks
    ub_mode = 0;
    plan_words(6'h10, 4);
    push_req(6'h10, 6'd4);
    send_cmd(6'h10, 7'd4);
    @(negedge clk);
    chk("lat_start_after_accept", ub_rd_start_out, 1);
    @(negedge clk);
    chk("lat_valid_not_yet", host_valid_out, 0);
    @(negedge clk);
    chk("lat_valid_after_data", host_valid_out, 1);
    wait_done(1, 100, "t1_done_once");

    // len 10 split 4,4,2; lanes alternate so lane 2 lags lane 1
    ub_mode = 1;
    plan_words(6'h20, 10);
    push_req(6'h20, 6'd4);
    push_req(6'h24, 6'd4);
    push_req(6'h28, 6'd2);
    send_cmd(6'h20, 7'd10);
    wait_done(2, 300, "t2_done_once");

    // address wrap: 0x3E then 0x02
    ub_mode = 0;
    plan_words(6'h3E, 6);
    push_req(6'h3E, 6'd4);
    push_req(6'h02, 6'd2);
    send_cmd(6'h3E, 7'd6);
    wait_done(3, 200, "t3_done_once");

    // host stalled: only DEPTH words may be requested
    host_ready_in = 1'b0;
    plan_words(6'h00, 12);
    push_req(6'h00, 6'd4);
    push_req(6'h04, 6'd4);
    push_req(6'h08, 6'd4);
    s0 = start_cnt;
    send_cmd(6'h00, 7'd12);
    repeat (40) @(negedge clk);
    chk("bp_requests_held", start_cnt - s0, 2);
    chk("bp_host_valid", host_valid_out, 1);
    chk("bp_no_done", done_cnt, 3);
    @(posedge clk);
    #1 host_ready_in = 1'b1;
    wait_done(4, 300, "t4_done_once");
    chk("bp_total_requests", start_cnt - s0, 3);

    // zero-length command, then a spurious lane-2 word in IDLE
    s0 = start_cnt;
    send_cmd(6'h05, 7'd0);
    @(negedge clk);
    chk("len0_done_pulse", done_out, 1);
    @(negedge clk);
    chk("len0_done_one_cycle", done_out, 0);
    chk("len0_done_count", done_cnt, 5);
    chk("len0_no_request", start_cnt - s0, 0);
    chk("err_clear_before_spur", err_overflow_out, 0);
    spur_req_n++;
    repeat (3) @(negedge clk);
    chk("err_after_spur", err_overflow_out, 1);
    chk("idle_after_spur", cmd_ready_out, 1);

    // reset while waiting for UB data, then a clean command
    ub_pause = 1'b1;
    plan_words(6'h30, 8);
    push_req(6'h30, 6'd4);
    send_cmd(6'h30, 7'd8);
    repeat (5) @(negedge clk);
    chk("wait_busy", cmd_ready_out, 0);
    chk("wait_req_seen", exp_req.size(), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_cmd_ready", cmd_ready_out, 1);
    chk("midrst_err_cleared", err_overflow_out, 0);
    chk("midrst_start", ub_rd_start_out, 0);
    chk("midrst_host_valid", host_valid_out, 0);
    chk("midrst_done", done_out, 0);
    exp_host.delete();
    ub_words.delete();
    ub_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ub_mode = 0;
    plan_words(6'h08, 4);
    push_req(6'h08, 6'd4);
    send_cmd(6'h08, 7'd4);
    wait_done(6, 100, "post_rst_done_once");
    chk("post_rst_err", err_overflow_out, 0);

    chk("end_host_queue_empty", exp_host.size(), 0);
    chk("end_req_queue_empty", exp_req.size(), 0);
    chk("end_ub_words_empty", ub_words.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
